// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared defaults and unit indices for the CDB arbiter
package cdb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int TAG_W_DEF   = 6;
  localparam int DATA_W_DEF  = 32;

  typedef enum int unsigned {
    ALU    = 0,
    MULT   = 1,
    LDST   = 2,
    BRANCH = 3
  } cdb_unit_e;

  // Pointer width that stays legal for a single-requester build.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter
  import cdb_pkg::*;
#(
  parameter int N     = NUM_REQ_DEF,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  int   idx;
  logic found;

  // Walk N slots from ptr with wraparound; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_regdest,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          p_rd,
  output logic [DATA_W-1:0]         wr_data_out,
  output logic                      RegDest_compl,
  output logic [NUM_REQ-1:0]        cdb_src
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_regdest;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Reset and flush both squash acceptance, so nothing is taken from a unit then.
  assign req_ready = (rst && !flush) ? grant : '0;
  assign xfer      = |req_ready;

  always_comb begin
    sel_tag     = '0;
    sel_data    = '0;
    sel_regdest = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_tag     = req_tag[i*TAG_W +: TAG_W];
        sel_data    = req_data[i*DATA_W +: DATA_W];
        sel_regdest = req_regdest[i];
      end
    end
    ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= '0;
      cdb_valid     <= 1'b0;
      RegDest_compl <= 1'b0;
      cdb_src       <= '0;
      p_rd          <= '0;
      wr_data_out   <= '0;
    end else begin
      cdb_valid     <= xfer;
      cdb_src       <= req_ready;
      // Tag 0 is the hardwired zero register: broadcast it but never write the PRF.
      RegDest_compl <= xfer && sel_regdest && (sel_tag != '0);
      if (xfer) begin
        p_rd        <= sel_tag;
        wr_data_out <= sel_data;
        rr_ptr      <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter against a queue-level model
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = NUM_REQ_DEF;
  localparam int TW = TAG_W_DEF;
  localparam int DW = DATA_W_DEF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_regdest = '0;
  logic [N-1:0]    req_ready;
  logic            flush = 1'b0;
  logic            cdb_valid;
  logic [TW-1:0]   p_rd;
  logic [DW-1:0]   wr_data_out;
  logic            RegDest_compl;
  logic [N-1:0]    cdb_src;

  cdb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_tag       (req_tag),
    .req_data      (req_data),
    .req_regdest   (req_regdest),
    .req_ready     (req_ready),
    .flush         (flush),
    .cdb_valid     (cdb_valid),
    .p_rd          (p_rd),
    .wr_data_out   (wr_data_out),
    .RegDest_compl (RegDest_compl),
    .cdb_src       (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [TW-1:0] prd;
    logic [DW-1:0] data;
    logic          rc;
    logic [N-1:0]  src;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int            m_ptr = 0;
  logic [TW-1:0] m_prd = '0;
  logic [DW-1:0] m_data = '0;

  logic [TW-1:0] tag_a[N];
  logic [DW-1:0] data_a[N];
  logic          rd_a[N];
  logic [N-1:0]  last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid unit at or after p, wrapping; -1 when none.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      tag_a[i]  = TW'($urandom);
      data_a[i] = $urandom;
      rd_a[i]   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic fl, input logic r);
    int           g;
    exp_t         e;
    logic [N-1:0] er;
    @(negedge clk);
    rst       = r;
    flush     = fl;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = tag_a[i];
      req_data[i*DW +: DW] = data_a[i];
      req_regdest[i]       = rd_a[i];
    end
    #1;
    if (!r) begin
      m_ptr  = 0;
      m_prd  = '0;
      m_data = '0;
    end
    g  = (r && !fl) ? model_grant(v, m_ptr) : -1;
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    last_ready = req_ready;
    e.v  = (g >= 0);
    e.rc = 1'b0;
    if (g >= 0) begin
      m_prd  = tag_a[g];
      m_data = data_a[g];
      e.rc   = rd_a[g] && (tag_a[g] != '0);
      m_ptr  = (g + 1) % N;
    end
    e.prd  = m_prd;
    e.data = m_data;
    e.src  = er;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
        chk("p_rd", 64'(p_rd), 64'(e.prd));
        chk("wr_data_out", 64'(wr_data_out), 64'(e.data));
        chk("RegDest_compl", 64'(RegDest_compl), 64'(e.rc));
        chk("cdb_src", 64'(cdb_src), 64'(e.src));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int wait_cnt;
    rand_payload();
    #1 rst = 1'b0;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_RegDest_compl", 64'(RegDest_compl), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_p_rd", 64'(p_rd), 64'd0);
    chk("rst_wr_data_out", 64'(wr_data_out), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    step('1, 1'b0, 1'b0);
    step('1, 1'b0, 1'b0);

    // All units valid from reset: strict rotation 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      step('1, 1'b0, 1'b1);
      chk("rr_rotation", 64'(last_ready), 64'(N'(1) << (i % N)));
    end

    // Single request from LDST.
    tag_a[LDST] = 6'h15; data_a[LDST] = 32'hDEADBEEF; rd_a[LDST] = 1'b1;
    step(4'b0100, 1'b0, 1'b1);
    chk("single_ready", 64'(last_ready), 64'h4);
    @(posedge clk); #2;
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_p_rd", 64'(p_rd), 64'h15);
    chk("single_data", 64'(wr_data_out), 64'hDEADBEEF);
    chk("single_rc", 64'(RegDest_compl), 64'd1);
    chk("single_src", 64'(cdb_src), 64'h4);

    // Tag zero broadcasts without a PRF write.
    tag_a[ALU] = '0; rd_a[ALU] = 1'b1;
    step(4'b0001, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("tag0_valid", 64'(cdb_valid), 64'd1);
    chk("tag0_rc", 64'(RegDest_compl), 64'd0);

    // Flush with rr_ptr at 1, then release.
    rand_payload();
    step(4'b1010, 1'b1, 1'b1);
    chk("flush_ready", 64'(last_ready), 64'd0);
    @(posedge clk); #2;
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    step(4'b1010, 1'b0, 1'b1);
    chk("post_flush_ready", 64'(last_ready), 64'h2);

    // Asynchronous reset while a broadcast is on the bus.
    tag_a[LDST] = 6'h2A; data_a[LDST] = 32'h12345678; rd_a[LDST] = 1'b1;
    step(4'b0100, 1'b0, 1'b1);
    @(posedge clk); #3;
    chk("pre_reset_valid", 64'(cdb_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("async_RegDest_compl", 64'(RegDest_compl), 64'd0);
    chk("async_p_rd", 64'(p_rd), 64'd0);
    chk("async_wr_data_out", 64'(wr_data_out), 64'd0);
    chk("async_cdb_src", 64'(cdb_src), 64'd0);
    step(4'b1100, 1'b0, 1'b0);
    step(4'b1100, 1'b0, 1'b1);
    chk("post_reset_grant", 64'(last_ready), 64'h4);

    // Unit 0 held valid while the others toggle: bounded wait between grants.
    wait_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      rand_payload();
      step({3'($urandom), 1'b1}, 1'b0, 1'b1);
      if (last_ready[0]) wait_cnt = 0;
      else wait_cnt++;
      chk("unit0_starvation", 64'(wait_cnt > N - 1), 64'd0);
    end

    // Fully random traffic with occasional flushes.
    for (int i = 0; i < 500; i++) begin
      rand_payload();
      step(N'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
    end

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    @(posedge clk); #3;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of completing functional units (0 ALU, 1 MULT, 2 LDST, 3 BRANCH).
REQ-002 Parameter TAG_W, default 6: physical register tag width (64 PRF entries).
REQ-003 Parameter DATA_W, default 32: result data width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-unit result available.
REQ-007 req_tag  input  NUM_REQ*TAG_W  per-unit destination physical tag, unit i at bits [i*TAG_W +: TAG_W].
REQ-008 req_data  input  NUM_REQ*DATA_W  per-unit result value, packed as req_tag.
REQ-009 req_regdest  input  NUM_REQ  per-unit flag: result writes a register.
REQ-010 req_ready  output  NUM_REQ  per-unit acceptance, one-hot or zero.
REQ-011 flush  input  1  squash all in-flight results (branch mispredict).
REQ-012 cdb_valid  output  1  CDB broadcast valid.
REQ-013 p_rd  output  TAG_W  CDB tag / PRF write address.
REQ-014 wr_data_out  output  DATA_W  CDB value / PRF write data.
REQ-015 RegDest_compl  output  1  PRF write enable.
REQ-016 cdb_src  output  NUM_REQ  one-hot source unit of current broadcast.

Function
REQ-017 Transfer on unit i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 req_ready SHALL be combinational from req_valid, pointer and flush; at most one bit high per cycle; never high for an invalid unit.
REQ-019 Grant SHALL be round-robin: search starts at index rr_ptr, wraps NUM_REQ-1 to 0; first valid unit wins.
REQ-020 After a transfer from unit i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no transfer rr_ptr SHALL hold.
REQ-021 Output stage SHALL be registered: accepted tag/data/regdest appear on p_rd/wr_data_out/RegDest_compl with cdb_valid=1 exactly one cycle after transfer.
REQ-022 With no transfer in a cycle, cdb_valid, RegDest_compl and cdb_src SHALL be 0 next cycle; p_rd/wr_data_out hold last value.
REQ-023 RegDest_compl SHALL equal accepted regdest AND (tag != 0); tag 0 never writes the PRF but still broadcasts cdb_valid=1.
REQ-024 Throughput SHALL be one result per cycle; output stage never back-pressures (PRF write always accepted).
REQ-025 While flush=1, req_ready SHALL be all zero; next cycle cdb_valid, RegDest_compl and cdb_src SHALL be 0; rr_ptr holds.
REQ-026 A unit held valid without grant SHALL keep its request; it SHALL be granted within NUM_REQ cycles of continuous validity (no starvation).
REQ-027 Inputs of non-granted units SHALL be ignored; changing them has no effect on outputs.

Reset
REQ-028 On rst=0, immediately and independent of clk: cdb_valid=0, RegDest_compl=0, cdb_src=0, p_rd=0, wr_data_out=0, rr_ptr=0.
REQ-029 While rst=0, req_ready SHALL be all zero.
REQ-030 Reset asserted mid-transfer SHALL discard the pending result; first grant after release starts search at index 0.

Structure
REQ-031 Shared package cdb_pkg SHALL hold TAG_W, DATA_W, NUM_REQ defaults and unit index constants (ALU, MULT, LDST, BRANCH).
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector, pointer; outputs one-hot grant, grant index).
REQ-033 cdb_arbiter SHALL contain only the pointer register, output register stage and flush/reset gating.

Verification
REQ-034 Single request: unit 2 valid, tag 0x15, data 0xDEADBEEF, regdest 1 -> req_ready=0100 same cycle; next cycle cdb_valid=1, p_rd=0x15, wr_data_out=0xDEADBEEF, RegDest_compl=1, cdb_src=0100.
REQ-035 All four units valid continuously from reset -> grants 0,1,2,3,0,... one per cycle, cdb_valid high every cycle after first.
REQ-036 Tag zero: unit 0, tag 0, regdest 1 -> cdb_valid=1, RegDest_compl=0 next cycle.
REQ-037 Flush: units 1 and 3 valid, flush=1 -> req_ready=0000, next cycle cdb_valid=0; flush drop with rr_ptr=1 -> unit 1 granted.
REQ-038 Async reset: drive rst=0 between clock edges while cdb_valid=1 -> cdb_valid, RegDest_compl, p_rd clear without a clock edge; after release units 2,3 valid -> unit 2 granted first.
REQ-039 Starvation: unit 0 valid continuously, units 1-3 toggling randomly -> unit 0 granted within 4 cycles of each prior grant.
